disp_search_engine: RTL and testbench

Parametrised, handshaked disparity search engine for one reference pixel. It captures a WIN-row strip from the left and right images together with a column index. It evaluates MAX_DISP candidate disparities in groups of DISP_THREADS parallel SAD units and returns the lowest-cost disparity and its SAD. It sits between the row-strip line buffer and the disparity-map writer, and generalises the single-pass search with valid/ready flow control, out-of-image candidate masking, deterministic tie-breaking and optional early exit.

---
 rtl/disp_pkg.sv | 23 ++
 rtl/disp_sad_unit.sv | 33 +++
 rtl/disp_search_engine.sv | 193 +++++++++++++++++++
 tb/tb_disp_search_engine.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and width helpers for the disparity search engine.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int sad_bits_f(input int win, input int data_size);
    return $clog2(win * win * ((32'sd1 <<< data_size) - 32'sd1) + 32'sd1);
  endfunction

  function automatic int disp_bits_f(input int max_disp);
    return $clog2(max_disp);
  endfunction

  function automatic int grp_bits_f(input int groups);
    return (groups > 32'sd1) ? $clog2(groups) : 32'sd1;
  endfunction

endpackage

// File: rtl/disp_sad_unit.sv
// Combinational WINxWIN absolute-difference sum; a masked candidate reports all-ones.
module disp_sad_unit
  import disp_pkg::*;
#(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int SAD_BITS  = sad_bits_f(WIN, DATA_SIZE)
) (
  input  logic [DATA_SIZE*WIN*WIN-1:0] win_l,
  input  logic [DATA_SIZE*WIN*WIN-1:0] win_r,
  input  logic                         cand_valid,
  output logic [SAD_BITS-1:0]          sad
);

  logic [SAD_BITS-1:0] sad_acc_s;
  logic [DATA_SIZE-1:0] pix_l_s;
  logic [DATA_SIZE-1:0] pix_r_s;

  // Accumulate at full SAD width so the sum can never wrap
  always_comb begin
    sad_acc_s = '0;
    pix_l_s   = '0;
    pix_r_s   = '0;
    for (int i = 0; i < WIN * WIN; i++) begin
      pix_l_s   = win_l[DATA_SIZE*i +: DATA_SIZE];
      pix_r_s   = win_r[DATA_SIZE*i +: DATA_SIZE];
      sad_acc_s = sad_acc_s + SAD_BITS'((pix_l_s >= pix_r_s) ? (pix_l_s - pix_r_s)
                                                             : (pix_r_s - pix_l_s));
    end
    sad = cand_valid ? sad_acc_s : '1;
  end

endmodule

// File: rtl/disp_search_engine.sv
// Handshaked disparity search over MAX_DISP candidates in groups of DISP_THREADS.
// Optional early exit on a zero-cost match: define DISP_EARLY_EXIT_EN.
module disp_search_engine
  import disp_pkg::*;
#(
  parameter int WIN          = 15,
  parameter int DATA_SIZE    = 8,
  parameter int IMG_W        = 64,
  parameter int MAX_DISP     = 64,
  parameter int DISP_THREADS = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_SIZE*IMG_W*WIN-1:0]        input_array_L,
  input  logic [DATA_SIZE*IMG_W*WIN-1:0]        input_array_R,
  input  logic [$clog2(IMG_W)-1:0]              col_index,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [disp_bits_f(MAX_DISP)-1:0]      output_disp,
  output logic [sad_bits_f(WIN, DATA_SIZE)-1:0] output_sad
);

  localparam int G         = MAX_DISP / DISP_THREADS;
  localparam int SAD_BITS  = sad_bits_f(WIN, DATA_SIZE);
  localparam int DISP_BITS = disp_bits_f(MAX_DISP);
  localparam int GRP_BITS  = grp_bits_f(G);
  localparam int STRIP_W   = DATA_SIZE * IMG_W * WIN;
  localparam int WIN_W     = DATA_SIZE * WIN * WIN;

  state_t                 state_r;
  logic [STRIP_W-1:0]     strip_l_r;
  logic [STRIP_W-1:0]     strip_r_r;
  logic [$clog2(IMG_W)-1:0] col_r;
  logic [GRP_BITS-1:0]    group_idx_r;
  logic [SAD_BITS-1:0]    best_sad_r;
  logic [DISP_BITS-1:0]   best_disp_r;
  logic [SAD_BITS-1:0]    sad_r [DISP_THREADS];
  logic [SAD_BITS-1:0]    sad_s [DISP_THREADS];
  logic [WIN_W-1:0]       win_l_s;
  logic [SAD_BITS-1:0]    grp_min_sad_s;
  logic [DISP_BITS-1:0]   grp_min_disp_s;
  logic [SAD_BITS-1:0]    next_best_sad_s;
  logic [DISP_BITS-1:0]   next_best_disp_s;
  logic                   early_exit_s;
  logic                   last_grp_s;

  // Left window is identical for every candidate, so it is extracted once
  always_comb begin
    int lc;
    lc      = 0;
    win_l_s = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        lc = int'(col_r) + c;
        if (lc < IMG_W) begin
          win_l_s[DATA_SIZE*(r*WIN+c) +: DATA_SIZE] = strip_l_r[DATA_SIZE*(r*IMG_W+lc) +: DATA_SIZE];
        end else begin
          win_l_s[DATA_SIZE*(r*WIN+c) +: DATA_SIZE] = '0;
        end
      end
    end
  end

  for (genvar t = 0; t < DISP_THREADS; t++) begin : g_thread
    logic [WIN_W-1:0] win_r_s;
    logic             cand_ok_s;

    // Right window for candidate base+t; columns past the strip edge read as zero and are masked
    always_comb begin
      int d;
      int rc;
      d         = int'(group_idx_r) * DISP_THREADS + t;
      rc        = 0;
      cand_ok_s = (int'(col_r) + d + WIN - 1) <= (IMG_W - 1);
      win_r_s   = '0;
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          rc = int'(col_r) + d + c;
          if (rc < IMG_W) begin
            win_r_s[DATA_SIZE*(r*WIN+c) +: DATA_SIZE] = strip_r_r[DATA_SIZE*(r*IMG_W+rc) +: DATA_SIZE];
          end else begin
            win_r_s[DATA_SIZE*(r*WIN+c) +: DATA_SIZE] = '0;
          end
        end
      end
    end

    disp_sad_unit #(
      .WIN       (WIN),
      .DATA_SIZE (DATA_SIZE),
      .SAD_BITS  (SAD_BITS)
    ) u_sad (
      .win_l      (win_l_s),
      .win_r      (win_r_s),
      .cand_valid (cand_ok_s),
      .sad        (sad_s[t])
    );
  end

  // Group minimum (lowest index wins ties) and strict-less best update
  always_comb begin
    int  idx;
    logic take;
    idx           = 0;
    grp_min_sad_s = sad_r[0];
    for (int t = 1; t < DISP_THREADS; t++) begin
      take          = sad_r[t] < grp_min_sad_s;
      idx           = take ? t : idx;
      grp_min_sad_s = take ? sad_r[t] : grp_min_sad_s;
    end
    grp_min_disp_s   = DISP_BITS'(int'(group_idx_r) * DISP_THREADS + idx);
    take             = grp_min_sad_s < best_sad_r;
    next_best_sad_s  = take ? grp_min_sad_s : best_sad_r;
    next_best_disp_s = take ? grp_min_disp_s : best_disp_r;
  end

`ifdef DISP_EARLY_EXIT_EN
  assign early_exit_s = (next_best_sad_s == '0);
`else
  assign early_exit_s = 1'b0;
`endif
  assign last_grp_s = (group_idx_r == GRP_BITS'(G - 1));

  // Datapath capture: strips on accept, group SADs in COMPUTE
  always_ff @(posedge clk) begin
    if (rst && in_ready && in_valid) begin
      strip_l_r <= input_array_L;
      strip_r_r <= input_array_R;
    end
    if (rst && (state_r == COMPUTE)) begin
      sad_r <= sad_s;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      output_disp <= '0;
      output_sad  <= '0;
      col_r       <= '0;
      group_idx_r <= '0;
      best_sad_r  <= '1;
      best_disp_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r     <= COMPUTE;
            in_ready    <= 1'b0;
            col_r       <= col_index;
            group_idx_r <= '0;
            best_sad_r  <= '1;
            best_disp_r <= '0;
          end
        end
        COMPUTE: begin
          state_r <= COMPARE;
        end
        COMPARE: begin
          best_sad_r  <= next_best_sad_s;
          best_disp_r <= next_best_disp_s;
          if (last_grp_s || early_exit_s) begin
            state_r     <= DONE;
            out_valid   <= 1'b1;
            output_disp <= next_best_disp_s;
            output_sad  <= next_best_sad_s;
          end else begin
            state_r     <= COMPUTE;
            group_idx_r <= group_idx_r + GRP_BITS'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_search_engine.sv
// Self-checking bench for disp_search_engine (WIN=3, IMG_W=16, MAX_DISP=8, DISP_THREADS=4).
module tb_disp_search_engine;

  localparam int WIN       = 3;
  localparam int DS        = 8;
  localparam int IMG_W     = 16;
  localparam int MAX_DISP  = 8;
  localparam int DT        = 4;
  localparam int G         = MAX_DISP / DT;
  localparam int SAD_ONES  = 4095;
  localparam int SW        = DS * IMG_W * WIN;
`ifdef DISP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] strip_l;
  logic [SW-1:0] strip_r;
  logic [3:0]    col_index;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    output_disp;
  logic [11:0]   output_sad;

  logic [7:0] pl [WIN][IMG_W];
  logic [7:0] pr [WIN][IMG_W];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_search_engine #(
    .WIN(WIN), .DATA_SIZE(DS), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP), .DISP_THREADS(DT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_array_L(strip_l), .input_array_R(strip_r), .col_index(col_index),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_disp(output_disp), .output_sad(output_sad)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exhaustive search over all candidates, lowest d wins ties
  task automatic model(input int col, output int edisp, output int esad, output int elat);
    int best, bd, k, s;
    best = SAD_ONES; bd = 0; k = G;
    for (int g = 0; g < G; g++) begin
      for (int t = 0; t < DT; t++) begin
        int d;
        d = g * DT + t;
        if (col + d + WIN - 1 <= IMG_W - 1) begin
          s = 0;
          for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) begin
              int a, b;
              a = pl[r][col + c];
              b = pr[r][col + d + c];
              s += (a > b) ? a - b : b - a;
            end
          if (s < best) begin best = s; bd = d; end
        end
      end
      if (EARLY && best == 0 && k == G) k = g + 1;
    end
    edisp = bd; esad = best; elat = 2 * k + 1;
  endtask

  task automatic pack();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) begin
        strip_l[DS*(r*IMG_W+c) +: DS] = pl[r][c];
        strip_r[DS*(r*IMG_W+c) +: DS] = pr[r][c];
      end
  endtask

  task automatic fill_shift(input int s);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) pl[r][c] = 8'($urandom);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) pr[r][c] = (c >= s) ? pl[r][c-s] : 8'($urandom);
  endtask

  task automatic fill_const(input logic [7:0] lv, input logic [7:0] rv, input int rhi_from);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) begin
        pl[r][c] = lv;
        pr[r][c] = (c >= rhi_from) ? lv : rv;
      end
  endtask

  // One request: latency measured in edges counting the accept edge
  task automatic run(input string tag, input int col, input int stall);
    int edisp, esad, elat, n;
    model(col, edisp, esad, elat);
    pack();
    col_index = 4'(col);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, elat);
    check({tag, "_disp"}, output_disp, edisp);
    check({tag, "_sad"}, output_sad, esad);
    check({tag, "_in_ready_busy"}, in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_disp"}, output_disp, edisp);
      check({tag, "_stall_sad"}, output_sad, esad);
      check({tag, "_stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_release_valid"}, out_valid, 0);
    check({tag, "_release_in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; col_index = 4'd0;
    strip_l = '0; strip_r = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_disp", output_disp, 0);
    check("reset_sad", output_sad, 0);
    rst = 1'b1;

    fill_shift(5);             run("shift5", 2, 0);
    fill_shift(2);             run("shift2", 2, 0);
    fill_const(8'h10, 8'h10, 0); run("tie", 2, 0);
    fill_const(8'h20, 8'h00, 14); run("mask", 12, 0);
    fill_const(8'hFF, 8'h00, IMG_W); run("maxsad", 0, 3);
    fill_shift(0);             run("allinvalid", 15, 0);

    // Reset while the first group is being compared
    fill_shift(3);
    pack();
    col_index = 4'd1;
    @(negedge clk); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_disp", output_disp, 0);
    check("midrst_sad", output_sad, 0);
    rst = 1'b1;
    run("after_rst", 1, 0);

    for (int i = 0; i < 8; i++) begin
      fill_shift($urandom_range(0, 9));
      run("rand", $urandom_range(0, 15), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
